// File: rtl/immgen_pkg.sv
// Shared types for the immediate generator: format codes, opcodes, sign extension.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package immgen_pkg;

    // Immediate format selected by the opcode decode.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    // Major opcodes, instr[6:0].
    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM  = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_OP_32     = 7'h3B;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM    = 7'h73;

    // Sign-extend a 32-bit immediate to the widest supported XLEN; callers
    // cast the result down to their own XLEN.
    function automatic logic [63:0] sext(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/immgen_decode.sv
// Combinational opcode decode: instr -> {fmt, illegal, XLEN-wide immediate}.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a; the enclosing pipeline registers the result.
// Ports: instr (32b raw instruction), fmt (imm_fmt_e), illegal, imm (XLEN).
module immgen_decode
    import immgen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output imm_fmt_e        fmt,
    output logic            illegal,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Any encoding with instr[1:0] != 2'b11 misses every label and lands in
    // the default branch, so the compressed-space check needs no extra term.
    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: fmt = FMT_I;
            OPC_STORE:  fmt = FMT_S;
            OPC_BRANCH: fmt = FMT_B;
            OPC_LUI, OPC_AUIPC: fmt = FMT_U;
            OPC_JAL:    fmt = FMT_J;
            // funct3[2] set selects the CSR immediate forms (csrr*i).
            OPC_SYSTEM: fmt = instr[14] ? FMT_Z : FMT_I;
            OPC_OP:     fmt = FMT_NONE;
            OPC_OP_IMM_32: begin
                if (XLEN == 64) fmt = FMT_I;
                else            illegal = 1'b1;
            end
            OPC_OP_32: begin
                if (XLEN != 64) illegal = 1'b1;
            end
            default:    illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm32 = 32'd0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'd0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            FMT_Z: imm32 = {27'd0, instr[19:15]};
            default: imm32 = 32'd0;
        endcase
    end

    // FMT_Z has bit 31 clear, so sign extension is also its zero extension.
    assign imm = XLEN'(sext(imm32));

endmodule

// File: rtl/immgen_pipe.sv
// Registered immediate generator with a 2-entry (main + skid) output buffer.
// Latency: 1 cycle from input accept to out_valid when the buffer is empty.
// Backpressure: in_ready is registered, low only while the skid entry is full.
// Ports: clk, rst_n (async low), flush; in_valid/in_ready/in_instr/in_tag;
//        out_valid/out_ready/out_imm/out_fmt/out_illegal/out_tag.
module immgen_pipe
    import immgen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } res_t;

    localparam res_t RES_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};

    res_t             new_res;
    res_t             main_q, main_d;
    res_t             skid_q, skid_d;
    logic             main_vld, main_vld_d;
    logic             skid_vld, skid_vld_d;
    logic             rdy_q;
    logic             acc_in, acc_out;
    imm_fmt_e         dec_fmt;
    logic             dec_illegal;
    logic [XLEN-1:0]  dec_imm;

    immgen_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .fmt     (dec_fmt),
        .illegal (dec_illegal),
        .imm     (dec_imm)
    );

    assign new_res = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
    assign acc_in  = in_valid && rdy_q;
    assign acc_out = main_vld && out_ready;

    // rdy_q tracks !skid_vld, so acc_in and "skid full" never coincide;
    // the skid->main refill therefore never competes with a new input.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld;
        skid_vld_d = skid_vld;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (acc_out) begin
            if (skid_vld) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (acc_in) begin
                main_d     = new_res;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (acc_in) begin
            if (main_vld) begin
                skid_d     = new_res;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = new_res;
                main_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= RES_RST;
            skid_q   <= RES_RST;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_vld <= main_vld_d;
            skid_vld <= skid_vld_d;
            rdy_q    <= !skid_vld_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = main_vld;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
// Latency: checks result 1 cycle after accept.
// Backpressure: exercises skid fill/drain, flush and async reset.
module tb_immgen_pipe;
    import immgen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32;
    imm_fmt_e    fmt32;
    logic [31:0] tag32;

    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    imm_fmt_e    fmt64;
    logic [31:0] tag64;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    immgen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_tag(tag32)
    );

    immgen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .out_tag(tag64)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] e_imm32;
        logic [2:0]  e_fmt32;
        logic        e_ill32;
        logic [63:0] e_imm64;
        logic [2:0]  e_fmt64;
        logic        e_ill64;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, FMT_I,    1'b0, 64'hFFFFFFFFFFFFFFFF, FMT_I,    1'b0};
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, FMT_S,    1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_S,    1'b0};
        vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, FMT_B,    1'b0, 64'hFFFFFFFFFFFFFFF8, FMT_B,    1'b0};
        vecs[3]  = '{32'h300FD073, 32'h0000001F, FMT_Z,    1'b0, 64'h000000000000001F, FMT_Z,    1'b0};
        vecs[4]  = '{32'h123450B7, 32'h12345000, FMT_U,    1'b0, 64'h0000000012345000, FMT_U,    1'b0};
        vecs[5]  = '{32'hFFDFF06F, 32'hFFFFFFFC, FMT_J,    1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_J,    1'b0};
        vecs[6]  = '{32'h30029073, 32'h00000300, FMT_I,    1'b0, 64'h0000000000000300, FMT_I,    1'b0};
        vecs[7]  = '{32'h002081B3, 32'h00000000, FMT_NONE, 1'b0, 64'h0,                FMT_NONE, 1'b0};
        vecs[8]  = '{32'h0000003B, 32'h00000000, FMT_NONE, 1'b1, 64'h0,                FMT_NONE, 1'b0};
        vecs[9]  = '{32'h800000B7, 32'h80000000, FMT_U,    1'b0, 64'hFFFFFFFF80000000, FMT_U,    1'b0};
        vecs[10] = '{32'hFFF0009B, 32'h00000000, FMT_NONE, 1'b1, 64'hFFFFFFFFFFFFFFFF, FMT_I,    1'b0};
        vecs[11] = '{32'h00000010, 32'h00000000, FMT_NONE, 1'b1, 64'h0,                FMT_NONE, 1'b1};
        vecs[12] = '{32'h0000000F, 32'h00000000, FMT_I,    1'b0, 64'h0,                FMT_I,    1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_tag    = 32'd0;
        out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", 64'(vld32), 64'd0);
        chk("rst_out_imm",   64'(imm32), 64'd0);
        chk("rst_out_fmt",   64'(fmt32), 64'(FMT_NONE));
        chk("rst_out_ill",   64'(ill32), 64'd0);
        chk("rst_out_tag",   64'(tag32), 64'd0);
        chk("rst_out_imm64", imm64, 64'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 64'(rdy32), 64'd1);

        // Directed decode vectors, one at a time, consumer always ready
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_tag   = 32'hA000_0000 + i;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid32", i), 64'(vld32), 64'd1);
            chk($sformatf("v%0d_imm32",   i), 64'(imm32), 64'(vecs[i].e_imm32));
            chk($sformatf("v%0d_fmt32",   i), 64'(fmt32), 64'(vecs[i].e_fmt32));
            chk($sformatf("v%0d_ill32",   i), 64'(ill32), 64'(vecs[i].e_ill32));
            chk($sformatf("v%0d_tag32",   i), 64'(tag32), 64'(32'hA000_0000 + i));
            chk($sformatf("v%0d_valid64", i), 64'(vld64), 64'd1);
            chk($sformatf("v%0d_imm64",   i), imm64,      vecs[i].e_imm64);
            chk($sformatf("v%0d_fmt64",   i), 64'(fmt64), 64'(vecs[i].e_fmt64));
            chk($sformatf("v%0d_ill64",   i), 64'(ill64), 64'(vecs[i].e_ill64));
            chk($sformatf("v%0d_tag64",   i), 64'(tag64), 64'(32'hA000_0000 + i));
            tick();
            chk($sformatf("v%0d_drained", i), 64'(vld32), 64'd0);
        end

        // Back-pressure: three back-to-back inputs with consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = vecs[0].instr;
        in_tag    = 32'hB1;
        tick();
        chk("bp_a_valid", 64'(vld32), 64'd1);
        chk("bp_a_ready", 64'(rdy32), 64'd1);
        in_instr = vecs[1].instr;
        in_tag   = 32'hB2;
        tick();
        chk("bp_b_ready_drop", 64'(rdy32), 64'd0);
        chk("bp_b_head_tag", 64'(tag32), 64'hB1);
        in_instr = vecs[2].instr;
        in_tag   = 32'hB3;
        tick();
        chk("bp_c_held_ready", 64'(rdy32), 64'd0);
        chk("bp_c_held_tag", 64'(tag32), 64'hB1);
        tick();
        chk("bp_stable_imm", 64'(imm32), 64'hFFFFFFFF);
        chk("bp_stable_tag", 64'(tag32), 64'hB1);
        out_ready = 1'b1;
        tick();
        chk("bp_drain_b_valid", 64'(vld32), 64'd1);
        chk("bp_drain_b_tag", 64'(tag32), 64'hB2);
        chk("bp_drain_b_imm", 64'(imm32), 64'hFFFFFFFC);
        chk("bp_ready_rise", 64'(rdy32), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_drain_c_valid", 64'(vld32), 64'd1);
        chk("bp_drain_c_tag", 64'(tag32), 64'hB3);
        chk("bp_drain_c_imm", 64'(imm32), 64'hFFFFFFF8);
        tick();
        chk("bp_empty", 64'(vld32), 64'd0);

        // Flush with both entries full and a pending input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = vecs[3].instr;
        in_tag    = 32'hC1;
        tick();
        in_tag = 32'hC2;
        tick();
        chk("fl_full_ready", 64'(rdy32), 64'd0);
        in_tag = 32'hC3;
        flush  = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid_clear", 64'(vld32), 64'd0);
        chk("fl_ready_set", 64'(rdy32), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl_no_stale%0d", k), 64'(vld32), 64'd0);
        end

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = vecs[4].instr;
        in_tag    = 32'hD1;
        tick();
        in_valid = 1'b0;
        chk("ar_loaded", 64'(vld32), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid_clear", 64'(vld32), 64'd0);
        chk("ar_imm_clear", 64'(imm32), 64'd0);
        chk("ar_tag_clear", 64'(tag32), 64'd0);
        chk("ar_fmt_clear", 64'(fmt32), 64'(FMT_NONE));
        #2 rst_n = 1'b1;
        tick();
        chk("ar_ready_back", 64'(rdy32), 64'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = vecs[9].instr;
        in_tag    = 32'hE1;
        tick();
        in_valid = 1'b0;
        chk("ar_first_valid", 64'(vld32), 64'd1);
        chk("ar_first_tag", 64'(tag32), 64'hE1);
        chk("ar_first_imm64", imm64, 64'hFFFFFFFF80000000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
